program_sequencer: RTL and testbench
====================================

# program_sequencer

Parametrised next-generation program counter for the RISC datapath. Holds the current instruction address and selects the next one from hold, increment, absolute load, PC-relative branch, subroutine call or return. Includes a return-address stack of configurable depth and sticky error flags. Drives the bus mux directly and is controlled by the control unit one operation per cycle.

## Interface
- ADDR_WIDTH, 32: PC / D / bus width in bits.
- INIT, 0: PC value loaded on reset.
- INSTRUCTION_SIZE, 1: increment step and call link offset.
- OFFSET_WIDTH, 19: width of signed branch offset, ≤ ADDR_WIDTH.
- STACK_DEPTH, 4: return-stack entries, ≥ 2.
- clock  in  1: single clock, rising edge.
- clear_n  in  1: asynchronous, active-low reset.
- enable  in  1: absolute load, PC ← D.
- inc  in  1: PC ← PC + INSTRUCTION_SIZE.
- branch  in  1: PC ← PC + sext(offset).
- call  in  1: push PC + INSTRUCTION_SIZE, then PC ← D.
- ret  in  1: PC ← popped address.
- err_clr  in  1: synchronous clear of overflow/underflow.
- D  in  ADDR_WIDTH: load/call target.
- offset  in  OFFSET_WIDTH: two's-complement branch displacement.
- BusMuxIn  out  ADDR_WIDTH: current PC.
- stack_count  out  $clog2(STACK_DEPTH+1): valid stack entries.
- stack_empty  out  1: stack_count == 0.
- stack_full  out  1: stack_count == STACK_DEPTH.
- overflow  out  1: sticky, call issued while full.
- underflow  out  1: sticky, ret issued while empty.

## Operation
- Fixed priority each cycle: enable > call > ret > branch > inc > hold. Only the highest asserted operation executes. Lower ones are ignored, with no side effects on stack or flags.
- All PC arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- offset is sign-extended to ADDR_WIDTH. The target is relative to the current PC, not PC + INSTRUCTION_SIZE.
- call when not full: writes link to top, count +1.
- call when full: link overwrites the oldest entry (circular). Count stays STACK_DEPTH, overflow ← 1, PC ← D regardless.
- ret when non-empty: PC ← top entry, count −1.
- ret when empty: PC holds, underflow ← 1.
- err_clr clears both flags. If err_clr and a new error occur in the same cycle, the flag ends set (set wins).
- enable, branch, inc and hold never touch the stack.

## Timing
- All state updates on the rising clock edge. BusMuxIn is a register output: the new PC is visible the cycle after the operation is sampled. No combinational path from inputs to outputs.
- stack_count, stack_empty, stack_full and the flags also update on that same edge.
- Reset (clear_n low, any time, including mid-call/ret) takes effect immediately:
  - BusMuxIn = INIT
  - stack_count = 0, stack_empty = 1, stack_full = 0
  - overflow = 0, underflow = 0
- Stack RAM contents are not reset and are unobservable while empty.
- Operation resumes on the first rising edge after clear_n deasserts.
- Back-to-back call/ret in consecutive cycles is fully supported; throughput is one op per cycle.

## Structure
- Shared package pc_pkg:
  - op-select enum (OP_HOLD, OP_INC, OP_BRANCH, OP_RET, OP_CALL, OP_LOAD);
  - priority encoder function from the request bits;
  - STACK_PTR_W helper derived from STACK_DEPTH.
- Sub-module return_stack (depth, width parameters) owns storage, circular top pointer, count, full/empty and push/pop. It has no knowledge of PC semantics. program_sequencer owns the PC register, next-PC mux and flags.

## Test plan
- Reset: INIT=32'h100; drop clear_n mid-cycle → BusMuxIn = 32'h100 immediately, stack_count = 0, flags = 0.
- Inc and wrap: PC = 32'hFFFF_FFFF, inc=1 → next cycle PC = 32'h0. With inc+branch asserted together, only the branch applies.
- Branch sign: PC = 32'h40, offset = −8 (19'h7FFF8) → PC = 32'h38. With offset = +16 → PC = 32'h50.
- Call/ret nest:
  - PC = 32'h10, call with D = 32'h80 → PC = 32'h80, count = 1.
  - call with D = 32'hA0 → count = 2.
  - Two rets → PC = 32'h81, then 32'h11; stack_empty = 1.
- Overflow: STACK_DEPTH = 4, five calls → overflow = 1, count = 4. Four rets return links 5, 4, 3, 2 (link 1 lost).
- Underflow and priority:
  - ret on empty → PC unchanged, underflow = 1.
  - err_clr → 0.
  - enable+call with D = 32'h200 → PC = 32'h200, count unchanged.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program sequencer.
//   op_t        : operation selected for the current cycle
//   op_select   : fixed-priority encoder (enable > call > ret > branch > inc)
//   stack_ptr_w : width of a pointer that indexes a stack of the given depth
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_BRANCH = 3'd2,
        OP_RET    = 3'd3,
        OP_CALL   = 3'd4,
        OP_LOAD   = 3'd5
    } op_t;

    function automatic op_t op_select(input logic enable, input logic call,
                                      input logic ret, input logic branch,
                                      input logic inc);
        if (enable)      return OP_LOAD;
        else if (call)   return OP_CALL;
        else if (ret)    return OP_RET;
        else if (branch) return OP_BRANCH;
        else if (inc)    return OP_INC;
        else             return OP_HOLD;
    endfunction

    function automatic int unsigned stack_ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular LIFO of DEPTH words. A push while full overwrites the oldest entry
// and keeps count at DEPTH. A pop while empty does nothing.
//   clock, clear_n : clock, asynchronous active-low reset (pointer/count only)
//   push, push_data: write push_data as the new top
//   pop            : discard the top entry
//   top_data       : current top entry (undefined while empty)
//   count          : number of valid entries
//   empty, full    : count == 0, count == DEPTH
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       clear_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = stack_ptr_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] ptr_prev;

    // Explicit wrap so non-power-of-two depths stay circular.
    always_comb begin
        ptr_next = (top == LAST) ? '0 : top + 1'b1;
        ptr_prev = (top == '0) ? LAST : top - 1'b1;
    end

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign top_data = mem[top];

    // Reset parks the pointer on the last slot so the first push lands in slot 0.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            top   <= LAST;
            count <= '0;
        end else if (push) begin
            top <= ptr_next;
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            top   <= ptr_prev;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[ptr_next] <= push_data;
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with hold / increment / load / relative branch / call / ret
// and a return-address stack with sticky overflow/underflow flags.
//   clock, clear_n      : clock, asynchronous active-low reset
//   enable, D           : PC <- D
//   call                : push PC + INSTRUCTION_SIZE, PC <- D
//   ret                 : PC <- popped address (hold + underflow if empty)
//   branch, offset      : PC <- PC + sext(offset)
//   inc                 : PC <- PC + INSTRUCTION_SIZE
//   err_clr             : clear overflow/underflow (a new error in the same cycle wins)
//   BusMuxIn            : registered current PC
//   stack_count/empty/full, overflow, underflow : stack status
module program_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] INIT       = '0,
    parameter int unsigned     INSTRUCTION_SIZE = 1,
    parameter int unsigned     OFFSET_WIDTH     = 19,
    parameter int unsigned     STACK_DEPTH      = 4
) (
    input  logic                             clock,
    input  logic                             clear_n,
    input  logic                             enable,
    input  logic                             inc,
    input  logic                             branch,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             err_clr,
    input  logic [ADDR_WIDTH-1:0]            D,
    input  logic [OFFSET_WIDTH-1:0]          offset,
    output logic [ADDR_WIDTH-1:0]            BusMuxIn,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             stack_empty,
    output logic                             stack_full,
    output logic                             overflow,
    output logic                             underflow
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTRUCTION_SIZE);

    op_t                  op;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] offset_ext;
    logic [ADDR_WIDTH-1:0] top_data;
    logic                  push;
    logic                  pop;

    assign op         = op_select(enable, call, ret, branch, inc);
    assign pc_inc     = pc + STEP;
    assign offset_ext = ADDR_WIDTH'($signed(offset));
    assign push       = (op == OP_CALL);
    assign pop        = (op == OP_RET);

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_stack (
        .clock     (clock),
        .clear_n   (clear_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .count     (stack_count),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    always_comb begin
        pc_next = pc;
        case (op)
            OP_LOAD:   pc_next = D;
            OP_CALL:   pc_next = D;
            OP_RET:    pc_next = stack_empty ? pc : top_data;
            OP_BRANCH: pc_next = pc + offset_ext;
            OP_INC:    pc_next = pc_inc;
            default:   pc_next = pc;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pc        <= INIT;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc        <= pc_next;
            overflow  <= (overflow  & ~err_clr) | (push & stack_full);
            underflow <= (underflow & ~err_clr) | (pop  & stack_empty);
        end
    end

    assign BusMuxIn = pc;

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        enable = 1'b0, inc = 1'b0, branch = 1'b0, call = 1'b0;
    logic        ret = 1'b0, err_clr = 1'b0;
    logic [31:0] D = '0;
    logic [18:0] offset = '0;
    logic [31:0] BusMuxIn;
    logic [2:0]  stack_count;
    logic        stack_empty, stack_full, overflow, underflow;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clock = ~clock;

    program_sequencer #(
        .ADDR_WIDTH       (32),
        .INIT             (32'h100),
        .INSTRUCTION_SIZE (1),
        .OFFSET_WIDTH     (19),
        .STACK_DEPTH      (4)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .enable      (enable),
        .inc         (inc),
        .branch      (branch),
        .call        (call),
        .ret         (ret),
        .err_clr     (err_clr),
        .D           (D),
        .offset      (offset),
        .BusMuxIn    (BusMuxIn),
        .stack_count (stack_count),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    typedef struct {
        logic        en, cl, rt, br, in, clr;
        logic [31:0] d;
        logic [18:0] off;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ovf, unf;
    } vec_t;

    vec_t table_v[$];
    vec_t sb[$];
    int   sb_idx[$];

    function automatic vec_t mk(input logic en, cl, rt, br, in, clr,
                                input logic [31:0] d, input logic [18:0] off,
                                input logic [31:0] pc, input logic [2:0] cnt,
                                input logic ovf, unf);
        vec_t v;
        v.en = en; v.cl = cl; v.rt = rt; v.br = br; v.in = in; v.clr = clr;
        v.d = d; v.off = off; v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc,
                             input logic [2:0] cnt, input logic ovf, input logic unf);
        chk({tag, " pc"},    BusMuxIn, pc);
        chk({tag, " count"}, 32'(stack_count), 32'(cnt));
        chk({tag, " empty"}, 32'(stack_empty), 32'(cnt == 3'd0));
        chk({tag, " full"},  32'(stack_full),  32'(cnt == 3'd4));
        chk({tag, " ovf"},   32'(overflow), 32'(ovf));
        chk({tag, " unf"},   32'(underflow), 32'(unf));
    endtask

    // Scoreboard consumer: results of the op driven at the previous negedge
    // are visible just after this rising edge.
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            vec_t e;
            int   idx;
            e   = sb.pop_front();
            idx = sb_idx.pop_front();
            chk_state($sformatf("step%0d", idx), e.pc, e.cnt, e.ovf, e.unf);
        end
    end

    task automatic step(input vec_t v, input int idx);
        @(negedge clock);
        enable = v.en; call = v.cl; ret = v.rt; branch = v.br; inc = v.in;
        err_clr = v.clr; D = v.d; offset = v.off;
        sb.push_back(v);
        sb_idx.push_back(idx);
    endtask

    task automatic idle();
        @(negedge clock);
        enable = 0; call = 0; ret = 0; branch = 0; inc = 0; err_clr = 0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
            sb.delete();
            sb_idx.delete();
        end
    endtask

    initial begin
        // en cl rt br in clr   D            off        pc          cnt ovf unf
        table_v.push_back(mk(0,0,0,0,0,0, 32'h0,        19'h0,     32'h100,      0,0,0));
        table_v.push_back(mk(0,0,0,0,1,0, 32'h0,        19'h0,     32'h101,      0,0,0));
        table_v.push_back(mk(1,0,0,0,0,0, 32'hFFFFFFFF, 19'h0,     32'hFFFFFFFF, 0,0,0));
        table_v.push_back(mk(0,0,0,0,1,0, 32'h0,        19'h0,     32'h0,        0,0,0));
        table_v.push_back(mk(1,0,0,0,0,0, 32'h40,       19'h0,     32'h40,       0,0,0));
        table_v.push_back(mk(0,0,0,1,1,0, 32'h0,        19'h7FFF8, 32'h38,       0,0,0));
        table_v.push_back(mk(1,0,0,0,0,0, 32'h40,       19'h0,     32'h40,       0,0,0));
        table_v.push_back(mk(0,0,0,1,0,0, 32'h0,        19'h10,    32'h50,       0,0,0));
        table_v.push_back(mk(1,0,0,0,0,0, 32'h10,       19'h0,     32'h10,       0,0,0));
        table_v.push_back(mk(0,1,0,0,0,0, 32'h80,       19'h0,     32'h80,       1,0,0));
        table_v.push_back(mk(0,1,0,0,0,0, 32'hA0,       19'h0,     32'hA0,       2,0,0));
        table_v.push_back(mk(0,0,1,0,0,0, 32'h0,        19'h0,     32'h81,       1,0,0));
        table_v.push_back(mk(0,0,1,0,0,0, 32'h0,        19'h0,     32'h11,       0,0,0));
        table_v.push_back(mk(0,0,1,0,0,0, 32'h0,        19'h0,     32'h11,       0,0,1));
        table_v.push_back(mk(0,0,0,0,0,1, 32'h0,        19'h0,     32'h11,       0,0,0));
        table_v.push_back(mk(1,1,0,0,0,0, 32'h200,      19'h0,     32'h200,      0,0,0));
        table_v.push_back(mk(0,1,1,1,1,0, 32'h300,      19'h5,     32'h300,      1,0,0));
        table_v.push_back(mk(0,0,1,1,1,0, 32'h0,        19'h5,     32'h201,      0,0,0));
        // five calls into a 4-deep stack: link 0x202 is lost
        table_v.push_back(mk(0,1,0,0,0,0, 32'h1000,     19'h0,     32'h1000,     1,0,0));
        table_v.push_back(mk(0,1,0,0,0,0, 32'h2000,     19'h0,     32'h2000,     2,0,0));
        table_v.push_back(mk(0,1,0,0,0,0, 32'h3000,     19'h0,     32'h3000,     3,0,0));
        table_v.push_back(mk(0,1,0,0,0,0, 32'h4000,     19'h0,     32'h4000,     4,0,0));
        table_v.push_back(mk(0,1,0,0,0,0, 32'h5000,     19'h0,     32'h5000,     4,1,0));
        table_v.push_back(mk(0,0,1,0,0,0, 32'h0,        19'h0,     32'h4001,     3,1,0));
        table_v.push_back(mk(0,0,1,0,0,0, 32'h0,        19'h0,     32'h3001,     2,1,0));
        table_v.push_back(mk(0,0,1,0,0,0, 32'h0,        19'h0,     32'h2001,     1,1,0));
        table_v.push_back(mk(0,0,1,0,0,0, 32'h0,        19'h0,     32'h1001,     0,1,0));
        table_v.push_back(mk(0,0,1,0,0,0, 32'h0,        19'h0,     32'h1001,     0,1,1));
        // clear coinciding with a new underflow: underflow stays, overflow clears
        table_v.push_back(mk(0,0,1,0,0,1, 32'h0,        19'h0,     32'h1001,     0,0,1));
        table_v.push_back(mk(0,0,0,0,0,1, 32'h0,        19'h0,     32'h1001,     0,0,0));

        // Reset state while clear_n held low
        #12;
        chk_state("reset", 32'h100, 3'd0, 1'b0, 1'b0);
        @(negedge clock);
        clear_n = 1'b1;

        for (int i = 0; i < table_v.size(); i++)
            step(table_v[i], i);
        idle();
        drain();

        // Fill the stack and raise both flags, then drop reset mid-cycle.
        step(mk(0,1,0,0,0,0, 32'h600, 19'h0, 32'h600, 1,0,0), 100);
        step(mk(0,1,0,0,0,0, 32'h700, 19'h0, 32'h700, 2,0,0), 101);
        step(mk(0,1,0,0,0,0, 32'h800, 19'h0, 32'h800, 3,0,0), 102);
        step(mk(0,1,0,0,0,0, 32'h900, 19'h0, 32'h900, 4,0,0), 103);
        step(mk(0,1,0,0,0,0, 32'hA00, 19'h0, 32'hA00, 4,1,0), 104);
        idle();
        drain();
        // call still asserted across the reset: must have no effect
        @(posedge clock);
        call = 1'b1; D = 32'hBEEF;
        #3;
        clear_n = 1'b0;
        #1;
        chk_state("async_rst", 32'h100, 3'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk_state("rst_held", 32'h100, 3'd0, 1'b0, 1'b0);
        call = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        step(mk(0,0,0,0,1,0, 32'h0, 19'h0, 32'h101, 0,0,0), 200);
        step(mk(0,0,1,0,0,0, 32'h0, 19'h0, 32'h101, 0,0,1), 201);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
